// File: rtl/pkt_switch_pkg.sv
// Shared types and header constants for the packet switch and its output buffers.
package pkt_switch_pkg;
  localparam int PKT_DATA_W   = 8;
  localparam int HDR_ADDR_IDX = 0;
  localparam int HDR_LEN_IDX  = 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;

  typedef struct packed {
    logic                  eop;
    logic [PKT_DATA_W-1:0] data;
  } pkt_byte_t;
endpackage

// File: rtl/pkt_buf_mem.sv
// Packet byte storage: one synchronous write port, one asynchronous read port.
// The array has no reset; only committed slots are ever read as valid data.
module pkt_buf_mem
  import pkt_switch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  pkt_byte_t       wdata,
  input  logic [AW-1:0]   raddr,
  output pkt_byte_t       rdata
);
  pkt_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pkt_out_buffer.sv
// Store-and-forward buffer for one switch output; whole packets that do not fit are dropped.
// Optional length check enabled by PKT_OUT_BUFFER_LEN_CHECK_EN. Last byte in cycle N -> out_valid in N+2.
module pkt_out_buffer
  import pkt_switch_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic          drop,
  output logic [AW:0]   level
);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  wr_state_t   state;
  logic [AW:0] wr_ptr, cm_ptr, rd_ptr;
  logic [7:0]  hold;
  logic        full, len_ok, mem_we, mem_eop, pop;
  pkt_byte_t   wdata, rdata;

`ifdef PKT_OUT_BUFFER_LEN_CHECK_EN
  logic [8:0]  cnt;
  logic [7:0]  len;
  // len counts every byte including the two header bytes
  assign len_ok = (cnt >= 9'd2) && (cnt == {1'b0, len});
`else
  assign len_ok = 1'b1;
`endif

  // Fullness uses the pre-edge rd_ptr, so a same-cycle pop never frees a slot early.
  assign full = (wr_ptr - rd_ptr) == CAP;

  always_comb begin
    mem_we  = 1'b0;
    mem_eop = 1'b0;
    if (state == RECV && !full) begin
      if (in_valid) begin
        mem_we = 1'b1;
      end else if (len_ok) begin
        mem_we  = 1'b1;
        mem_eop = 1'b1;
      end
    end
  end

  assign wdata = '{eop: mem_eop, data: hold};

  pkt_buf_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DROP;
      wr_ptr <= '0;
      cm_ptr <= '0;
      hold   <= '0;
      drop   <= 1'b0;
`ifdef PKT_OUT_BUFFER_LEN_CHECK_EN
      cnt    <= '0;
      len    <= '0;
`endif
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          hold  <= in_data;
          state <= RECV;
`ifdef PKT_OUT_BUFFER_LEN_CHECK_EN
          cnt   <= 9'd1;
`endif
        end
        RECV: begin
          if (in_valid) begin
            if (!full) begin
              hold   <= in_data;
              wr_ptr <= wr_ptr + 1'b1;
`ifdef PKT_OUT_BUFFER_LEN_CHECK_EN
              if (cnt != 9'h1FF) cnt <= cnt + 9'd1;
              if (cnt == 9'(HDR_LEN_IDX)) len <= in_data;
`endif
            end else begin
              wr_ptr <= cm_ptr;
              drop   <= 1'b1;
              state  <= DROP;
            end
          end else begin
            if (mem_we) begin
              wr_ptr <= wr_ptr + 1'b1;
              cm_ptr <= wr_ptr + 1'b1;
            end else begin
              wr_ptr <= cm_ptr;
              drop   <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: if (!in_valid) state <= IDLE;
      endcase
    end
  end

  assign out_valid = (rd_ptr != cm_ptr);
  assign out_data  = rdata.data;
  assign out_eop   = rdata.eop;
  assign pop       = out_valid && out_ready;
  assign level     = cm_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      out_sop <= 1'b1;
    end else if (pop) begin
      rd_ptr  <= rd_ptr + 1'b1;
      out_sop <= out_eop;
    end
  end
endmodule
